// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, flag bit indices, branch conditions and FSM states shared by the execute stage
package exec_pkg;
  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_ADD  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_SETC = 4'd12;
  localparam logic [3:0] OP_CLRC = 4'd13;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam logic [1:0] COND_Z      = 2'b00;
  localparam logic [1:0] COND_N      = 2'b01;
  localparam logic [1:0] COND_C      = 2'b10;
  localparam logic [1:0] COND_ALWAYS = 2'b11;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MULT = 2'd1, ST_DONE = 2'd2} state_t;
  function automatic int condFlag(input logic [1:0] cond);
    return cond == COND_N ? FLAG_N : cond == COND_C ? FLAG_C : FLAG_Z;
  endfunction
endpackage

// File: rtl/exec_mul_iter.sv
// exec_mul_iter: iterative shift-add multiplier, one partial product per cycle, done on the last step
module exec_mul_iter #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CNT_W = $clog2(DATA_W);
  logic busy;
  logic [CNT_W-1:0] count;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  assign done = busy && count == CNT_W'(DATA_W - 1);
  // Latch operands on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      count <= '0;
      mcand <= '0;
      mplier <= '0;
      product <= '0;
    end else if (clear) begin
      busy <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy <= 1'b1;
      count <= '0;
      mcand <= {{DATA_W{1'b0}}, a};
      mplier <= b;
      product <= '0;
    end else if (busy) begin
      product <= mplier[0] ? product + mcand : product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      count <= count + CNT_W'(1);
      busy <= !done;
    end
endmodule

// File: rtl/execute_stage_mc.sv
// execute_stage_mc: ALU/branch/iterative-MUL execute stage with valid/ready on both sides; EXEC_FLAG_SAVE_EN adds a flag shadow register
module execute_stage_mc
  import exec_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              alu_src,
  input  logic              branch,
  input  logic [3:0]        func,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] imm,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic [TAG_W-1:0]  out_tag,
  output logic              branch_taken,
  output logic [2:0]        flags
`ifdef EXEC_FLAG_SAVE_EN
  ,
  input  logic              flag_save,
  input  logic              flag_restore
`endif
);
  localparam int SH_W = $clog2(DATA_W);
  state_t state, stateNext;
  logic [DATA_W-1:0] in1, aluRes;
  logic [DATA_W:0] wide;
  logic [SH_W-1:0] shamt;
  logic aluC, writeZN, writeOut, isMul, fire, taken, mulDone;
  logic [2:0] aluFlags, brFlags, flagsNext;
  logic [2*DATA_W-1:0] product;
  logic [TAG_W-1:0] mulTag;
  assign in1 = alu_src ? imm : read_data1;
  assign shamt = read_data2[SH_W-1:0];
  assign isMul = !branch && func == OP_MUL;
  assign fire = in_valid && in_ready && !flush;
  assign taken = func[1:0] == COND_ALWAYS || flags[condFlag(func[1:0])];
  exec_mul_iter #(.DATA_W(DATA_W)) mulIter (
    .clk(clk),
    .rst_n(rst_n),
    .clear(flush),
    .start(fire && isMul),
    .a(in1),
    .b(read_data2),
    .done(mulDone),
    .product(product)
  );
`ifdef EXEC_FLAG_SAVE_EN
  logic [2:0] shadow;
  // Shadow copy of the flags, sampled before this cycle's update
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) shadow <= '0;
    else if (flag_save) shadow <= flags;
`endif
  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= stateNext;
  // FSM next state: IDLE launches a MUL, MULT runs until the last partial product, DONE publishes it
  always_comb begin
    stateNext = state;
    if (flush) stateNext = ST_IDLE;
    else
      case (state)
        ST_IDLE: stateNext = fire && isMul ? ST_MULT : ST_IDLE;
        ST_MULT: stateNext = mulDone ? ST_DONE : ST_MULT;
        default: stateNext = ST_IDLE;
      endcase
  end
  // FSM outputs: accept only when idle and the output slot is free or draining
  always_comb in_ready = state == ST_IDLE && (!out_valid || out_ready);
  // Single-cycle ALU; carry/borrow comes from the extra top bit of the widened result
  always_comb begin
    wide = '0;
    aluRes = '0;
    aluC = flags[FLAG_C];
    writeZN = 1'b1;
    writeOut = 1'b1;
    case (func)
      OP_MOV:  aluRes = in1;
      OP_NOT:  aluRes = ~in1;
      OP_INC:  begin wide = {1'b0, in1} + (DATA_W+1)'(1); {aluC, aluRes} = wide; end
      OP_DEC:  begin wide = {1'b0, in1} - (DATA_W+1)'(1); {aluC, aluRes} = wide; end
      OP_ADD:  begin wide = {1'b0, in1} + {1'b0, read_data2}; {aluC, aluRes} = wide; end
      OP_SUB:  begin wide = {1'b0, in1} - {1'b0, read_data2}; {aluC, aluRes} = wide; end
      OP_AND:  aluRes = in1 & read_data2;
      OP_OR:   aluRes = in1 | read_data2;
      OP_SHL:  begin wide = {1'b0, in1} << shamt; {aluC, aluRes} = wide; end
      OP_SHR:  begin wide = {in1, 1'b0} >> shamt; {aluRes, aluC} = wide; end
      OP_SETC: begin aluC = 1'b1; writeZN = 1'b0; end
      OP_CLRC: begin aluC = 1'b0; writeZN = 1'b0; end
      default: begin writeZN = 1'b0; writeOut = 1'b0; end
    endcase
  end
  // Next flag value from MUL completion, ALU op or branch; restore overrides everything
  always_comb begin
    aluFlags = flags;
    aluFlags[FLAG_C] = aluC;
    if (writeZN) begin
      aluFlags[FLAG_Z] = aluRes == '0;
      aluFlags[FLAG_N] = aluRes[DATA_W-1];
    end
    brFlags = flags;
    if (taken && func[1:0] != COND_ALWAYS) brFlags[condFlag(func[1:0])] = 1'b0;
    flagsNext = flags;
    if (flush) flagsNext = flags;
    else if (state == ST_DONE) begin
      flagsNext[FLAG_Z] = product == '0;
      flagsNext[FLAG_C] = |product[2*DATA_W-1:DATA_W];
      flagsNext[FLAG_N] = product[2*DATA_W-1];
    end else if (fire && !isMul) flagsNext = branch ? brFlags : aluFlags;
`ifdef EXEC_FLAG_SAVE_EN
    if (flag_restore) flagsNext = shadow;
`endif
  end
  // Flag register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flags <= '0;
    else flags <= flagsNext;
  // Output slot: loaded by an accepted op or MUL completion, held under back-pressure
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      result <= '0;
      result_hi <= '0;
      out_tag <= '0;
      branch_taken <= 1'b0;
      mulTag <= '0;
    end else if (flush) out_valid <= 1'b0;
    else if (state == ST_DONE) begin
      out_valid <= 1'b1;
      result <= product[DATA_W-1:0];
      result_hi <= product[2*DATA_W-1:DATA_W];
      out_tag <= mulTag;
      branch_taken <= 1'b0;
    end else if (fire) begin
      out_valid <= branch || writeOut;
      if (isMul) mulTag <= in_tag;
      if (branch || writeOut) begin
        result <= branch ? (taken ? read_data1 : '0) : aluRes;
        result_hi <= '0;
        out_tag <= in_tag;
        branch_taken <= branch && taken;
      end
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_execute_stage_mc.sv
// tb_execute_stage_mc: scoreboard bench for execute_stage_mc at DATA_W=16, TAG_W=3
module tb_execute_stage_mc;
  import exec_pkg::*;
  typedef struct {
    logic [15:0] res;
    logic [15:0] hi;
    logic [2:0]  tag;
    logic        tk;
    logic        chkRes;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, alu_src, branch, out_valid, out_ready, branch_taken;
  logic [3:0] func;
  logic [15:0] read_data1, read_data2, imm, result, result_hi;
  logic [2:0] in_tag, out_tag, flags;
  logic [2:0] tagCnt = 3'd0;
  int nVec = 0;
  int nMiss = 0;
  exp_t sb[$];
  exp_t got;
`ifdef EXEC_FLAG_SAVE_EN
  logic flag_save = 1'b0;
  logic flag_restore = 1'b0;
`endif
  execute_stage_mc #(.DATA_W(16), .TAG_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .alu_src(alu_src),
    .branch(branch),
    .func(func),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .imm(imm),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .result_hi(result_hi),
    .out_tag(out_tag),
    .branch_taken(branch_taken),
    .flags(flags)
`ifdef EXEC_FLAG_SAVE_EN
    ,
    .flag_save(flag_save),
    .flag_restore(flag_restore)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [3:0] f, input logic b, input logic src, input logic [15:0] a,
                      input logic [15:0] d2, input logic [15:0] im, input logic push,
                      input logic [15:0] eRes, input logic [15:0] eHi, input logic eTk, input logic eChk);
    int n;
    n = 0;
    func = f;
    branch = b;
    alu_src = src;
    read_data1 = a;
    read_data2 = d2;
    imm = im;
    in_tag = tagCnt;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      check("accept_timeout", n, 0);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    if (push) sb.push_back('{eRes, eHi, tagCnt, eTk, eChk});
    tagCnt++;
  endtask
  task automatic alu(input logic [3:0] f, input logic [15:0] a, input logic [15:0] d2, input logic [15:0] eRes);
    send(f, 1'b0, 1'b0, a, d2, 16'h0, 1'b1, eRes, 16'h0, 1'b0, 1'b1);
  endtask
  task automatic jmp(input logic [1:0] c, input logic [15:0] tgt, input logic eTk);
    send({2'b00, c}, 1'b1, 1'b0, tgt, 16'h0, 16'h0, 1'b1, eTk ? tgt : 16'h0, 16'h0, eTk, eTk);
  endtask
  task automatic waitOut(output int n, output int hi);
    n = 0;
    hi = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) hi++;
      tick();
      n++;
    end
  endtask
  // Scoreboard: pop one expectation per completed output handshake
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_underflow", 1, 0);
      else begin
        got = sb.pop_front();
        if (got.chkRes) check("result", result, got.res);
        check("result_hi", result_hi, got.hi);
        check("out_tag", out_tag, got.tag);
        check("branch_taken", branch_taken, got.tk);
      end
    end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n, hi, bad;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    alu_src = 1'b0;
    branch = 1'b0;
    func = OP_NOP;
    read_data1 = '0;
    read_data2 = '0;
    imm = '0;
    in_tag = '0;
    repeat (2) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();
    alu(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000);
    check("add_valid_lat1", out_valid, 1);
    check("add_flags", flags, 3'b011);
    jmp(COND_Z, 16'h0040, 1'b1);
    check("jz_taken", branch_taken, 1);
    check("jz_flags", flags, 3'b010);
    jmp(COND_Z, 16'h0040, 1'b0);
    check("jz2_taken", branch_taken, 0);
    check("jz2_flags", flags, 3'b010);
    send(OP_MUL, 1'b0, 1'b0, 16'h1234, 16'h0100, 16'h0, 1'b1, 16'h3400, 16'h0012, 1'b0, 1'b1);
    waitOut(n, hi);
    check("mul_latency", n, 17);
    check("mul_in_ready_high", hi, 0);
    check("mul_flags", flags, 3'b010);
    tick();
    out_ready = 1'b0;
    alu(OP_ADD, 16'd3, 16'd4, 16'd7);
    check("hold_add_flags", flags, 3'b000);
    func = OP_SUB;
    branch = 1'b0;
    read_data1 = 16'd9;
    read_data2 = 16'd3;
    in_tag = tagCnt;
    in_valid = 1'b1;
    bad = 0;
    repeat (5) begin
      tick();
      if (!(out_valid && result == 16'd7 && !in_ready)) bad++;
    end
    check("hold_stable", bad, 0);
    sb.push_back('{16'd6, 16'h0, tagCnt, 1'b0, 1'b1});
    tagCnt++;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("hold_release", result, 16'd6);
    send(OP_SETC, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    check("setc_flags", flags, 3'b010);
    send(OP_MUL, 1'b0, 1'b0, 16'h0000, 16'h0005, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (6) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    bad = 0;
    repeat (20) begin
      tick();
      if (out_valid) bad++;
    end
    check("flush_no_output", bad, 0);
    check("flush_flags", flags, 3'b010);
    alu(OP_MOV, 16'hBEEF, 16'h0, 16'hBEEF);
    check("mov_flags", flags, 3'b110);
    send(OP_MUL, 1'b0, 1'b0, 16'h00FF, 16'h00FF, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("rstmul_out_valid", out_valid, 0);
    check("rstmul_result", result, 0);
    check("rstmul_out_tag", out_tag, 0);
    check("rstmul_flags", flags, 0);
    check("rstmul_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    alu(OP_SHL, 16'h8001, 16'd1, 16'h0002);
    check("shl_flags", flags, 3'b010);
    alu(OP_SHR, 16'h0003, 16'd1, 16'h0001);
    check("shr_flags", flags, 3'b010);
    alu(OP_SHL, 16'h0005, 16'd0, 16'h0005);
    check("shl0_flags", flags, 3'b000);
    alu(OP_SHL, 16'h0001, 16'd20, 16'h0010);
    check("shl_mask_flags", flags, 3'b000);
    alu(OP_SUB, 16'd5, 16'd7, 16'hFFFE);
    check("sub_borrow_flags", flags, 3'b110);
    jmp(COND_ALWAYS, 16'h1234, 1'b1);
    check("jmp_flags", flags, 3'b110);
    jmp(COND_N, 16'h2222, 1'b1);
    check("jn_flags", flags, 3'b010);
    alu(OP_AND, 16'hF0F0, 16'h0F0F, 16'h0000);
    check("and_flags", flags, 3'b011);
    jmp(COND_C, 16'h3333, 1'b1);
    check("jc_flags", flags, 3'b001);
    jmp(COND_C, 16'h3333, 1'b0);
    check("jc2_flags", flags, 3'b001);
    alu(OP_DEC, 16'h0000, 16'h0, 16'hFFFF);
    check("dec_flags", flags, 3'b110);
    send(OP_INC, 1'b0, 1'b1, 16'hDEAD, 16'h0, 16'h7FFF, 1'b1, 16'h8000, 16'h0, 1'b0, 1'b1);
    check("inc_imm_flags", flags, 3'b100);
    send(OP_NOP, 1'b0, 1'b0, 16'h1111, 16'h1, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("nop_valid", out_valid, 0);
    send(4'd14, 1'b0, 1'b0, 16'h1111, 16'h1, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    check("op14_valid", out_valid, 0);
    check("op14_flags", flags, 3'b100);
    alu(OP_NOT, 16'hFFFF, 16'h0, 16'h0000);
    check("not_flags", flags, 3'b001);
    send(OP_SETC, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    check("setc2_flags", flags, 3'b011);
    send(OP_CLRC, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    check("clrc_flags", flags, 3'b001);
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a, b, r;
      logic [16:0] w;
      logic [3:0] f;
      int k;
      k = $urandom_range(0, 3);
      a = 16'($urandom);
      b = 16'($urandom);
      w = '0;
      case (k)
        0: begin f = OP_ADD; w = {1'b0, a} + {1'b0, b}; r = w[15:0]; end
        1: begin f = OP_SUB; w = {1'b0, a} - {1'b0, b}; r = w[15:0]; end
        2: begin f = OP_AND; r = a & b; end
        default: begin f = OP_OR; r = a | b; end
      endcase
      alu(f, a, b, r);
      check("rnd_z", flags[0], r == 16'h0);
      check("rnd_n", flags[2], r[15]);
      if (k < 2) check("rnd_c", flags[1], w[16]);
    end
    send(OP_MUL, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b1, 16'h0001, 16'hFFFE, 1'b0, 1'b1);
    waitOut(n, hi);
    check("mul2_latency", n, 17);
    check("mul2_flags", flags, 3'b110);
    tick();
`ifdef EXEC_FLAG_SAVE_EN
    alu(OP_SUB, 16'd5, 16'd7, 16'hFFFE);
    flag_save = 1'b1;
    tick();
    flag_save = 1'b0;
    alu(OP_SUB, 16'd5, 16'd5, 16'h0000);
    check("save_sub_flags", flags, 3'b001);
    flag_restore = 1'b1;
    tick();
    flag_restore = 1'b0;
    check("restore_flags", flags, 3'b110);
`endif
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end
endmodule
